// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage sitting directly downstream of the
//               program counter. Issues in-order read requests to instruction
//               memory over a req/gnt/rvalid interface, buffers returned words
//               (tagged with their PC) in a small in-order queue and hands them
//               to decode with a valid/ready handshake. Holds the PC through
//               stall_o whenever the current PC cannot be requested, and
//               discards in-flight/buffered fetches when a jump loads the PC.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W   PC / instruction-memory address width
//   INSTR_W  instruction word width
//   DEPTH    queue entries = max outstanding requests (power of 2, >= 2)
// Ports:
//   clk_i          in   clock
//   rst_n_i        in   synchronous active-low reset
//   pc_i           in   current PC value
//   flush_i        in   jump taken this cycle
//   stall_o        out  1 = hold PC
//   imem_req_o     out  fetch request valid
//   imem_addr_o    out  fetch address (= pc_i)
//   imem_gnt_i     in   request accepted this cycle
//   imem_rvalid_i  in   response valid (in order)
//   imem_rdata_i   in   response data
//   instr_valid_o  out  head instruction valid
//   instr_o        out  head instruction
//   instr_pc_o     out  PC of the head instruction
//   instr_ready_i  in   decode accepts the head
// Optional feature (macro FETCH_PERF_EN):
//   perf_fetched_o out  saturating count of instructions handed to decode
//   perf_stall_o   out  saturating count of stall cycles outside flushes
// ============================================================================
module fetch_stage #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched_o,
  output logic [15:0]        perf_stall_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  // Counters must be able to hold the value DEPTH itself.
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  // Queue storage
  logic [ADDR_W-1:0]  entry_pc   [DEPTH];
  logic [INSTR_W-1:0] entry_data [DEPTH];
  logic [DEPTH-1:0]   entry_filled;

  // wr_ptr: next slot to allocate; fill_ptr: oldest allocated-but-unfilled
  // slot; rd_ptr: head slot presented to decode.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // used: allocated entries; pend: allocated entries still waiting for data;
  // discard: responses still owed for requests issued before a flush.
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] discard;

  logic [CNT_W:0]   inflight;
  logic             room;
  logic             alloc;
  logic             fill;
  logic             drop;
  logic             pop;
  logic             rsp_owed;
  logic [CNT_W-1:0] flush_discard;

  always_comb begin
    // Old-stream responses still owed occupy capacity just like live entries,
    // so the total outstanding never exceeds DEPTH.
    inflight      = {1'b0, used} + {1'b0, discard};
    room          = (inflight < DEPTH_EXT);

    imem_req_o    = rst_n_i && !flush_i && room;
    imem_addr_o   = pc_i;
    alloc         = imem_req_o && imem_gnt_i;
    stall_o       = !alloc;

    instr_valid_o = rst_n_i && !flush_i && (used != '0) && entry_filled[rd_ptr];
    instr_o       = entry_data[rd_ptr];
    instr_pc_o    = entry_pc[rd_ptr];
    pop           = instr_valid_o && instr_ready_i;

    // Responses belong to the discarded stream first (they are in order).
    drop          = imem_rvalid_i && (discard != '0);
    fill          = imem_rvalid_i && (discard == '0) && (pend != '0);

    // On a flush every unfilled entry turns into a response to discard,
    // except one that is already arriving this very cycle. A stray rvalid
    // with nothing owed must not take the count below zero.
    rsp_owed      = (discard != '0) || (pend != '0);
    flush_discard = discard + pend - CNT_W'(imem_rvalid_i && rsp_owed);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr       <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      used         <= '0;
      pend         <= '0;
      discard      <= '0;
      entry_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_pc[i]   <= '0;
        entry_data[i] <= '0;
      end
    end else if (flush_i) begin
      // No allocation can happen in a flush cycle and any pop is ignored,
      // so the queue simply restarts empty.
      wr_ptr       <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      used         <= '0;
      pend         <= '0;
      entry_filled <= '0;
      discard      <= flush_discard;
    end else begin
      // alloc, fill and pop always address distinct slots: alloc targets a
      // free slot, fill an allocated unfilled one, pop a filled one.
      if (alloc) begin
        entry_pc[wr_ptr]     <= pc_i;
        entry_filled[wr_ptr] <= 1'b0;
        wr_ptr               <= wr_ptr + PTR_W'(1);
      end
      if (fill) begin
        entry_data[fill_ptr]   <= imem_rdata_i;
        entry_filled[fill_ptr] <= 1'b1;
        fill_ptr               <= fill_ptr + PTR_W'(1);
      end
      if (pop) begin
        entry_filled[rd_ptr] <= 1'b0;
        rd_ptr               <= rd_ptr + PTR_W'(1);
      end
      used    <= used + CNT_W'(alloc) - CNT_W'(pop);
      pend    <= pend + CNT_W'(alloc) - CNT_W'(fill);
      discard <= discard - CNT_W'(drop);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (pop && (perf_fetched_o != 16'hFFFF)) begin
        perf_fetched_o <= perf_fetched_o + 16'd1;
      end
      if (stall_o && !flush_i && (perf_stall_o != 16'hFFFF)) begin
        perf_stall_o <= perf_stall_o + 16'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding is a memory-side protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!(imem_rvalid_i && (discard == '0) && (pend == '0)));
    end
  end
`endif

endmodule
`default_nettype wire
